// File: rtl/display_pkg.sv
// Shared types and defaults for the display path: SRAM geometry, the
// read-arbiter state encoding and the read-latency tags.
package display_pkg;

   localparam int unsigned DEF_ADDR_W = 20;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE_HI,
      ISSUE_LO,
      DRAIN
   } arb_state_t;

   typedef enum logic [1:0] {
      TAG_NONE,
      TAG_HI,
      TAG_LO
   } rd_tag_t;

endpackage

// File: rtl/fixed_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins; one-hot grant plus
// binary index. Purely combinational.
module fixed_prio_enc #(
   parameter  int unsigned N     = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !any) begin
            gnt[i] = 1'b1;
            idx    = IDX_W'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_read_arbiter.sv
// Shares the 16-bit SRAM read port among the overlay image readers; each grant
// performs two reads (A, A+1) and returns one 32-bit word {data(A), data(A+1)}.
module sram_read_arbiter
   import display_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_refresh,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*ADDR_W-1:0] i_addr,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [N_REQ-1:0]        o_valid,
   output logic [2*DATA_W-1:0]     o_q,
   output logic                    o_busy,
   output logic [ADDR_W-1:0]       o_sram_address,
   input  logic [DATA_W-1:0]       i_sram_data
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t        state;
   rd_tag_t           tag_pipe [RD_LAT];
   rd_tag_t           tag_in;
   rd_tag_t           tag_out;
   logic [N_REQ-1:0]  enc_gnt;
   logic [IDX_W-1:0]  enc_idx;
   logic              enc_any;
   logic              grant_now;
   logic [N_REQ-1:0]  owner;
   logic [ADDR_W-1:0] base_addr;
   logic [DATA_W-1:0] hi_half;

   fixed_prio_enc #(
      .N(N_REQ)
   ) u_enc (
      .req (i_req),
      .gnt (enc_gnt),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign grant_now = i_rst_n && !i_refresh && (state == IDLE) && enc_any;
   assign o_gnt     = grant_now ? enc_gnt : '0;
   assign o_busy    = (state != IDLE) || grant_now || (|o_valid);
   assign tag_out   = tag_pipe[RD_LAT-1];

   always_comb begin
      tag_in = TAG_NONE;
      if (state == ISSUE_HI) begin
         tag_in = TAG_HI;
      end else if (state == ISSUE_LO) begin
         tag_in = TAG_LO;
      end
   end

   // The tag pipe tracks which half each in-flight read belongs to, so data
   // capture is independent of the FSM state and works for any RD_LAT.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         owner          <= '0;
         base_addr      <= '0;
         hi_half        <= '0;
         o_valid        <= '0;
         o_q            <= '0;
         o_sram_address <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            tag_pipe[i] <= TAG_NONE;
         end
      end else begin
         o_valid <= '0;
         if (i_refresh) begin
            // Frame start abandons the transaction; o_q and the address hold.
            state <= IDLE;
            for (int unsigned i = 0; i < RD_LAT; i++) begin
               tag_pipe[i] <= TAG_NONE;
            end
         end else begin
            tag_pipe[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
               tag_pipe[i] <= tag_pipe[i-1];
            end

            if (tag_out == TAG_HI) begin
               hi_half <= i_sram_data;
            end
            if (tag_out == TAG_LO) begin
               o_q     <= {hi_half, i_sram_data};
               o_valid <= owner;
            end

            unique case (state)
               IDLE: begin
                  if (enc_any) begin
                     owner          <= enc_gnt;
                     base_addr      <= i_addr[enc_idx*ADDR_W +: ADDR_W];
                     o_sram_address <= i_addr[enc_idx*ADDR_W +: ADDR_W];
                     state          <= ISSUE_HI;
                  end
               end
               ISSUE_HI: begin
                  o_sram_address <= base_addr + ADDR_W'(1);
                  state          <= ISSUE_LO;
               end
               ISSUE_LO: begin
                  state <= DRAIN;
               end
               DRAIN: begin
                  if (tag_out == TAG_LO) begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: two instances (RD_LAT 1 and 3) share stimulus
// and are each compared every cycle with a transaction-level reference model.
module tb_sram_read_arbiter;

   localparam int unsigned NR   = 4;
   localparam int unsigned AW   = 20;
   localparam int unsigned DW   = 16;
   localparam int          NDUT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             refresh;
   logic [NR-1:0]    req;
   logic [NR*AW-1:0] addr;

   logic [NR-1:0]   gnt       [NDUT];
   logic [NR-1:0]   valid     [NDUT];
   logic [2*DW-1:0] q         [NDUT];
   logic            busy      [NDUT];
   logic [AW-1:0]   sram_addr [NDUT];
   logic [DW-1:0]   sram_data [NDUT];

   sram_read_arbiter #(
      .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)
   ) dut_lat1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_refresh(refresh), .i_req(req), .i_addr(addr),
      .o_gnt(gnt[0]), .o_valid(valid[0]), .o_q(q[0]), .o_busy(busy[0]),
      .o_sram_address(sram_addr[0]), .i_sram_data(sram_data[0])
   );

   sram_read_arbiter #(
      .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)
   ) dut_lat3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_refresh(refresh), .i_req(req), .i_addr(addr),
      .o_gnt(gnt[1]), .o_valid(valid[1]), .o_q(q[1]), .o_busy(busy[1]),
      .o_sram_address(sram_addr[1]), .i_sram_data(sram_data[1])
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state, one set per instance
   bit              act    [NDUT];
   int              t0     [NDUT];
   logic [NR-1:0]   own    [NDUT];
   logic [AW-1:0]   a_m    [NDUT];
   logic [AW-1:0]   addr_m [NDUT];
   logic [2*DW-1:0] q_m    [NDUT];

   // SRAM model: address seen in each past cycle
   logic [AW-1:0] hist     [NDUT][3];
   logic [AW-1:0] cur_addr [NDUT];

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      if (a == 20'h12340) return 16'hAAAA;
      if (a == 20'h12341) return 16'h5555;
      return a[15:0] ^ {a[19:16], a[19:8]} ^ 16'h6B3D;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act_v, input logic [63:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act_v, exp_v);
      end
   endtask

   task automatic model_check(input int d);
      logic [NR-1:0] e_gnt;
      logic [NR-1:0] e_valid;
      logic          e_busy;
      logic [AW-1:0] a1;
      int            sel;
      int            lat;
      lat     = lat_of(d);
      e_gnt   = '0;
      e_valid = '0;
      e_busy  = 1'b0;
      if (act[d]) begin
         e_busy = 1'b1;
         a1     = a_m[d] + 1'b1;
         if (cyc == t0[d] + 1) addr_m[d] = a_m[d];
         if (cyc == t0[d] + 2) addr_m[d] = a1;
         if (cyc == t0[d] + lat + 3) begin
            e_valid = own[d];
            q_m[d]  = {memf(a_m[d]), memf(a1)};
            act[d]  = 1'b0;
         end
      end
      if (!act[d] && rst_n && !refresh && req != '0) begin
         sel = 0;
         for (int k = NR - 1; k >= 0; k--) begin
            if (req[k]) sel = k;
         end
         own[d] = '0;
         own[d][sel] = 1'b1;
         a_m[d]  = addr[sel*AW +: AW];
         t0[d]   = cyc;
         act[d]  = 1'b1;
         e_gnt   = own[d];
         e_busy  = 1'b1;
      end
      chk($sformatf("gnt[%0d]", d),   64'(gnt[d]),       64'(e_gnt));
      chk($sformatf("valid[%0d]", d), 64'(valid[d]),     64'(e_valid));
      chk($sformatf("busy[%0d]", d),  64'(busy[d]),      64'(e_busy));
      chk($sformatf("q[%0d]", d),     64'(q[d]),         64'(q_m[d]));
      chk($sformatf("addr[%0d]", d),  64'(sram_addr[d]), 64'(addr_m[d]));
      if (!rst_n) begin
         act[d]    = 1'b0;
         q_m[d]    = '0;
         addr_m[d] = '0;
      end else if (refresh && act[d] && cyc != t0[d]) begin
         act[d] = 1'b0;
      end
   endtask

   task automatic cycle(input logic [NR-1:0] rq, input logic [NR*AW-1:0] ad,
                        input logic rf, input logic rn);
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         hist[d][2]   = hist[d][1];
         hist[d][1]   = hist[d][0];
         hist[d][0]   = cur_addr[d];
         sram_data[d] = memf(hist[d][lat_of(d) - 1]);
      end
      req     = rq;
      addr    = ad;
      refresh = rf;
      rst_n   = rn;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         model_check(d);
         cur_addr[d] = sram_addr[d];
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, addr, 1'b0, 1'b1);
   endtask

   initial begin
      logic [NR*AW-1:0] ad;
      logic [95:0]      rnd;
      logic [NR-1:0]    req_r;

      rst_n   = 1'b0;
      refresh = 1'b0;
      req     = '0;
      addr    = '0;
      for (int d = 0; d < NDUT; d++) begin
         act[d] = 1'b0; t0[d] = 0; own[d] = '0; a_m[d] = '0;
         addr_m[d] = '0; q_m[d] = '0; cur_addr[d] = '0; sram_data[d] = '0;
         for (int j = 0; j < 3; j++) hist[d][j] = '0;
      end
      repeat (2) @(posedge clk);

      // reset values
      cycle('0, '0, 1'b0, 1'b0);
      idle(2);

      // single request on index 2, directed SRAM contents
      ad = '0;
      ad[2*AW +: AW] = 20'h12340;
      cycle(4'b0100, ad, 1'b0, 1'b1);
      chk("single_gnt", 64'(gnt[0]), 64'(4'b0100));
      for (int i = 0; i < 7; i++) cycle('0, ad, 1'b0, 1'b1);
      chk("single_q_lat1", 64'(q[0]), 64'(32'hAAAA5555));
      chk("single_q_lat3", 64'(q[1]), 64'(32'hAAAA5555));

      // contention: lowest index served first, no fairness
      rnd = {$urandom(), $urandom(), $urandom()};
      ad  = rnd[NR*AW-1:0];
      for (int i = 0; i < 14; i++) cycle(4'b1011, ad, 1'b0, 1'b1);
      idle(8);

      // address wrap
      ad[0 +: AW] = 20'hFFFFF;
      cycle(4'b0001, ad, 1'b0, 1'b1);
      idle(7);
      chk("wrap_q_lat1", 64'(q[0]), 64'({memf(20'hFFFFF), memf(20'h00000)}));
      chk("wrap_q_lat3", 64'(q[1]), 64'({memf(20'hFFFFF), memf(20'h00000)}));

      // frame abort at T2, pending request blocked by refresh at T3
      cycle(4'b0001, ad, 1'b0, 1'b1);
      cycle('0, ad, 1'b0, 1'b1);
      cycle('0, ad, 1'b1, 1'b1);
      cycle(4'b0010, ad, 1'b1, 1'b1);
      chk("abort_busy", 64'(busy[0]), 64'(1'b0));
      chk("abort_gnt", 64'(gnt[0]), 64'(4'b0000));
      cycle(4'b0010, ad, 1'b0, 1'b1);
      idle(8);

      // reset mid-transaction
      cycle(4'b0100, ad, 1'b0, 1'b1);
      cycle('0, ad, 1'b0, 1'b0);
      cycle('0, ad, 1'b0, 1'b1);
      chk("rst_busy", 64'(busy[0]), 64'(1'b0));
      chk("rst_q", 64'(q[0]), 64'(0));
      cycle(4'b1000, ad, 1'b0, 1'b1);
      idle(8);

      // randomized traffic
      req_r = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req_r = NR'($urandom());
         rnd = {$urandom(), $urandom(), $urandom()};
         cycle(req_r, rnd[NR*AW-1:0], ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 63) != 0));
      end
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
